// File: rtl/cmem_loader.sv
// rtl/cmem_loader.sv - serial coefficient-memory load sequencer
// Accepts CMEMSIZE words over valid/ready, shifts each MSB-first into cmem and returns displaced words.
module cmem_loader #(
  parameter int CMEMSIZE = 4,
  parameter int DATABITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_in,
  input  logic                abort_in,
  input  logic                coef_valid_in,
  input  logic [DATABITS-1:0] coef_in,
  output logic                coef_ready_out,
  output logic                sde_out,
  output logic                sd_out,
  input  logic                sdo_in,
  output logic                old_valid_out,
  output logic [DATABITS-1:0] old_out,
  output logic                busy_out,
  output logic                done_out
);

  localparam int BW = (DATABITS > 1) ? $clog2(DATABITS) : 1;
  localparam int WW = (CMEMSIZE > 1) ? $clog2(CMEMSIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DATABITS-1:0] tx_q, tx_d;
  logic [DATABITS-1:0] rx_q, rx_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [WW-1:0]       word_q, word_d;
  logic                old_valid_q, old_valid_d;
  logic                word_end;
  logic                last_word;

  assign word_end  = (state_q == S_SHIFT) && (bit_q == BW'(DATABITS - 1));
  assign last_word = (word_q == WW'(CMEMSIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      old_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_q       <= bit_d;
      word_q      <= word_d;
      old_valid_q <= old_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_d       = bit_q;
    word_d      = word_q;
    old_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_WAIT;
          word_d  = '0;
          bit_d   = '0;
        end
      end
      S_WAIT: begin
        if (coef_valid_in) begin
          state_d = S_SHIFT;
          tx_d    = coef_in;
          bit_d   = '0;
        end
      end
      S_SHIFT: begin
        tx_d = {tx_q[DATABITS-2:0], 1'b0};
        rx_d = {rx_q[DATABITS-2:0], sdo_in};
        if (word_end) begin
          bit_d       = '0;
          old_valid_d = 1'b1;
          if (last_word) begin
            word_d  = '0;
            state_d = S_DONE;
          end else begin
            word_d  = word_q + WW'(1);
            state_d = S_WAIT;
          end
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything; the interrupted word never reports as displaced.
    if (abort_in && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      old_valid_d = 1'b0;
    end
  end

  assign coef_ready_out = (state_q == S_WAIT);
  assign sde_out        = (state_q == S_SHIFT);
  assign sd_out         = (state_q == S_SHIFT) && tx_q[DATABITS-1];
  assign old_valid_out  = old_valid_q;
  assign old_out        = rx_q;
  assign busy_out       = (state_q != S_IDLE);
  assign done_out       = (state_q == S_DONE);

endmodule

// File: tb/tb_cmem_loader.sv
// tb/tb_cmem_loader.sv - self-checking bench for cmem_loader
// Drives directed and random loads against a word-level cmem reference model.
module tb_cmem_loader;

  localparam int CM = 4;
  localparam int DB = 4;
  localparam int NB = CM * DB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_in = 1'b0;
  logic          abort_in = 1'b0;
  logic          coef_valid_in = 1'b0;
  logic [DB-1:0] coef_in = '0;
  logic          coef_ready_out, sde_out, sd_out, sdo_in;
  logic          old_valid_out, busy_out, done_out;
  logic [DB-1:0] old_out;

  cmem_loader #(.CMEMSIZE(CM), .DATABITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .abort_in(abort_in),
    .coef_valid_in(coef_valid_in), .coef_in(coef_in), .coef_ready_out(coef_ready_out),
    .sde_out(sde_out), .sd_out(sd_out), .sdo_in(sdo_in),
    .old_valid_out(old_valid_out), .old_out(old_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  // Physical scan chain of the cmem: entry k occupies bits [k*DB +: DB].
  logic [NB-1:0] chain;
  logic          preload = 1'b0;
  logic [NB-1:0] preload_val = '0;
  assign sdo_in = chain[NB-1];
  always @(posedge clk) begin
    if (preload) chain <= preload_val;
    else if (sde_out) chain <= {chain[NB-2:0], sd_out};
  end

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0, done_cnt = 0, old_cnt = 0, sde_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy_out) busy_cnt++;
    if (done_out) done_cnt++;
    if (old_valid_out) old_cnt++;
    if (sde_out) begin
      sde_run++;
      chk("sde_run_len", 32'(sde_run <= DB), 32'd1);
      chk("sde_implies_busy", 32'(busy_out), 32'd1);
    end else begin
      sde_run = 0;
    end
  end

  // Word-level reference: ref_mem[k] is cmem entry k.
  logic [DB-1:0] ref_mem [CM];
  logic [DB-1:0] load_w [CM];
  int            load_st [CM];

  task automatic do_preload(input logic [NB-1:0] v);
    preload_val = v;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    for (int k = 0; k < CM; k++) ref_mem[k] = v[k*DB +: DB];
  endtask

  task automatic sync_ref();
    for (int k = 0; k < CM; k++) ref_mem[k] = chain[k*DB +: DB];
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(coef_ready_out), 0);
    chk({tag, "_sde"}, 32'(sde_out), 0);
    chk({tag, "_sd"}, 32'(sd_out), 0);
    chk({tag, "_oldv"}, 32'(old_valid_out), 0);
    chk({tag, "_busy"}, 32'(busy_out), 0);
    chk({tag, "_done"}, 32'(done_out), 0);
  endtask

  // ab_word < 0 means run to completion; use_rst selects reset instead of abort.
  task automatic do_load(input int ab_word, input int ab_bit, input bit use_rst, input bit noise);
    int d0, o0, b0, stall_sum;
    logic [DB-1:0] exp_old;
    d0 = done_cnt; o0 = old_cnt; b0 = busy_cnt; stall_sum = 0;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    chk("busy_after_start", 32'(busy_out), 1);
    for (int i = 0; i < CM; i++) begin
      for (int s = 0; s < load_st[i]; s++) begin
        chk("stall_ready", 32'(coef_ready_out), 1);
        chk("stall_sde", 32'(sde_out), 0);
        @(negedge clk);
      end
      stall_sum += load_st[i];
      chk("ready_before_word", 32'(coef_ready_out), 1);
      coef_valid_in = 1'b1;
      coef_in = load_w[i];
      @(negedge clk);
      coef_valid_in = 1'b0;
      coef_in = DB'($urandom);
      exp_old = ref_mem[CM-1];
      for (int k = CM - 1; k > 0; k--) ref_mem[k] = ref_mem[k-1];
      ref_mem[0] = load_w[i];
      for (int b = 0; b < DB; b++) begin
        if (i == ab_word && b == ab_bit) begin
          if (use_rst) rst_n = 1'b0;
          else abort_in = 1'b1;
          @(negedge clk);
          abort_in = 1'b0;
          if (use_rst) begin
            check_all_zero("reset_mid_shift");
            chk("reset_old_out", 32'(old_out), 0);
            rst_n = 1'b1;
          end else begin
            check_all_zero("abort");
          end
          repeat (3) @(negedge clk);
          chk("no_done_after_stop", 32'(done_cnt - d0), 0);
          chk("no_oldv_for_cut_word", 32'(old_cnt - o0), 32'(i));
          sync_ref();
          return;
        end
        chk("sde_in_shift", 32'(sde_out), 1);
        chk("sd_bit", 32'(sd_out), 32'(load_w[i][DB-1-b]));
        if (noise && i == 1 && b == 1) start_in = 1'b1;
        if (noise && i == 2 && b == 0) coef_valid_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        coef_valid_in = 1'b0;
      end
      chk("old_valid", 32'(old_valid_out), 1);
      chk("old_out", 32'(old_out), 32'(exp_old));
      chk("done_at_word_end", 32'(done_out), 32'(i == CM - 1));
      chk("ready_at_word_end", 32'(coef_ready_out), 32'(i != CM - 1));
    end
    @(negedge clk);
    chk("idle_busy", 32'(busy_out), 0);
    chk("idle_done", 32'(done_out), 0);
    chk("done_pulses", 32'(done_cnt - d0), 1);
    chk("old_pulses", 32'(old_cnt - o0), 32'(CM));
    chk("busy_cycles", 32'(busy_cnt - b0), 32'(CM * (DB + 1) + 1 + stall_sum));
    for (int k = 0; k < CM; k++) chk("cmem_entry", 32'(chain[k*DB +: DB]), 32'(ref_mem[k]));
  endtask

  task automatic set_words(input logic [DB-1:0] a, b, c, d);
    load_w[0] = a; load_w[1] = b; load_w[2] = c; load_w[3] = d;
    for (int k = 0; k < CM; k++) load_st[k] = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    chk("reset_old_out", 32'(old_out), 0);
    rst_n = 1'b1;
    do_preload({4'hA, 4'hB, 4'hC, 4'hD});

    set_words(4'h1, 4'h2, 4'h3, 4'h4);
    do_load(0, 2, 1'b1, 1'b0);

    do_preload({4'hA, 4'hB, 4'hC, 4'hD});
    set_words(4'h1, 4'h2, 4'h3, 4'h4);
    do_load(-1, 0, 1'b0, 1'b0);
    chk("full_load_cmem", 32'(chain), 32'h1234);

    do_preload({4'hA, 4'hB, 4'hC, 4'hD});
    set_words(4'h1, 4'h2, 4'h3, 4'h4);
    load_st[2] = 5;
    do_load(-1, 0, 1'b0, 1'b0);
    chk("stall_load_cmem", 32'(chain), 32'h1234);

    set_words(4'h9, 4'hE, 4'h7, 4'h3);
    do_load(2, 1, 1'b0, 1'b0);
    set_words(4'h5, 4'h6, 4'h7, 4'h8);
    do_load(-1, 0, 1'b0, 1'b0);
    chk("reload_after_abort", 32'(chain), 32'h5678);

    coef_valid_in = 1'b1;
    coef_in = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid_ignored_busy", 32'(busy_out), 0);
      chk("idle_valid_ignored_ready", 32'(coef_ready_out), 0);
    end
    coef_valid_in = 1'b0;
    set_words(4'hC, 4'h0, 4'hF, 4'h1);
    do_load(-1, 0, 1'b0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < CM; k++) begin
        load_w[k] = DB'($urandom);
        load_st[k] = $urandom_range(0, 3);
      end
      do_load(-1, 0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
